// File: rtl/div_pkg.sv
// Shared arithmetic-unit definitions: FSM state encodings and counter width
// used by the non-restoring divider and the sequential Booth multiplier.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Wide enough to count iterations for operands up to 64 bits.
    localparam int DIV_CNT_W = 6;

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division step: shift in the next dividend
// bit, then subtract or add the divisor depending on the partial-remainder sign.
module nr_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic             qmsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             qbit
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] d_ext;

    always_comb begin
        r_shift = {r[WIDTH-1:0], qmsb};
        d_ext   = {1'b0, d};
        if (r[WIDTH] == 1'b0) begin
            r_next = r_shift - d_ext;
        end else begin
            r_next = r_shift + d_ext;
        end
        qbit = ~r_next[WIDTH];
    end

endmodule

// File: rtl/nr_divider.sv
// Iterative non-restoring integer divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement truncating division; default is unsigned.
module nr_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // state    | meaning
    // DIV_IDLE | no result yet since reset
    // DIV_ITER | one quotient bit per edge (or single pass for divide-by-zero)
    // DIV_FIX  | remainder correction and sign application
    // DIV_DONE | result held until next accepted start

    div_state_t state, state_nxt;

    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH:0]       r;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     d;
    logic                 dz;
    logic                 neg_q;
    logic                 neg_r;

    logic                 start_acc;
    logic                 last_iter;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH:0]       r_step;
    logic                 qbit_step;
    logic [WIDTH:0]       r_fix;

    assign start_acc = start && ((state == DIV_IDLE) || (state == DIV_DONE));
    assign last_iter = (cnt == DIV_CNT_W'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
    // Magnitude of MIN_INT is itself, which is correct read as unsigned.
    always_comb begin
        a_neg = dividend[WIDTH-1];
        b_neg = divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
    end
`else
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        a_mag = dividend;
        b_mag = divisor;
    end
`endif

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .qmsb   (q[WIDTH-1]),
        .d      (d),
        .r_next (r_step),
        .qbit   (qbit_step)
    );

    assign r_fix = r[WIDTH] ? (r + {1'b0, d}) : r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start_acc) state_nxt = DIV_ITER;
            end
            DIV_ITER: begin
                busy = 1'b1;
                if (dz)             state_nxt = DIV_DONE;
                else if (last_iter) state_nxt = DIV_FIX;
            end
            DIV_FIX: begin
                busy      = 1'b1;
                state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                if (start_acc) state_nxt = DIV_ITER;
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    assign div_by_zero = dz & done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            dz        <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start_acc) begin
            cnt   <= '0;
            r     <= '0;
            d     <= b_mag;
            dz    <= (divisor == '0);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            // Divide-by-zero parks the raw dividend in q to become the remainder.
            q     <= (divisor == '0) ? dividend : a_mag;
        end else begin
            case (state)
                DIV_ITER: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= q;
                    end else begin
                        r   <= r_step;
                        q   <= {q[WIDTH-2:0], qbit_step};
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_FIX: begin
                    r         <= r_fix;
                    quotient  <= neg_q ? (~q + 1'b1) : q;
                    remainder <= neg_r ? (~r_fix[WIDTH-1:0] + 1'b1) : r_fix[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// Directed self-checking bench for nr_divider (WIDTH=32), signed or unsigned build.
module tb_nr_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int passed = 0;
    int total  = 0;

    nr_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEADBEEF;
        divisor  = 32'h00000003;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                                input logic edz, input int elat, input int lat);
        total++;
        if (lat !== elat) $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        else passed++;
        total++;
        if (quotient !== eq) $display("FAIL %s quotient: got %h expected %h", name, quotient, eq);
        else passed++;
        total++;
        if (remainder !== er) $display("FAIL %s remainder: got %h expected %h", name, remainder, er);
        else passed++;
        total++;
        if (div_by_zero !== edz) $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, edz);
        else passed++;
    endtask

    task automatic test_reset;
        total++;
        if ({quotient, remainder} !== '0) $display("FAIL reset q/r: got %h/%h expected 0/0", quotient, remainder);
        else passed++;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset flags: got %b expected 000", {busy, done, div_by_zero});
        else passed++;
    endtask

    task automatic test_basic;
        int lat;
        launch(32'd100, 32'd7);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic busy after start: got busy=%b done=%b expected 1/0", busy, done);
        else passed++;
        wait_done(lat);
        check_result("100/7", 32'd14, 32'd2, 1'b0, 33, lat);
        total++;
        if (busy !== 1'b0) $display("FAIL basic busy at done: got %b expected 0", busy);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || quotient !== 32'd14) $display("FAIL basic hold: got done=%b q=%h expected 1/%h", done, quotient, 32'd14);
        else passed++;
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int lat;
        launch(32'hFFFFFF9C, 32'd7);
        wait_done(lat);
        check_result("-100/7", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, lat);
        launch(32'd100, 32'hFFFFFFF9);
        wait_done(lat);
        check_result("100/-7", 32'hFFFFFFF2, 32'd2, 1'b0, 33, lat);
        launch(32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        check_result("min/-1", 32'h80000000, 32'd0, 1'b0, 33, lat);
        launch(32'hFFFFFFF9, 32'hFFFFFFFE);
        wait_done(lat);
        check_result("-7/-2", 32'd3, 32'hFFFFFFFF, 1'b0, 33, lat);
    endtask
`else
    task automatic test_unsigned;
        int lat;
        launch(32'hFFFFFFFF, 32'd2);
        wait_done(lat);
        check_result("ffffffff/2", 32'h7FFFFFFF, 32'd1, 1'b0, 33, lat);
        launch(32'hFFFFFF9C, 32'd7);
        wait_done(lat);
        check_result("ffffff9c/7", 32'h24924916, 32'd2, 1'b0, 33, lat);
        launch(32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        check_result("80000000/ffffffff", 32'd0, 32'h80000000, 1'b0, 33, lat);
    endtask
`endif

    task automatic test_div_zero;
        int lat;
        launch(32'd5, 32'd0);
        wait_done(lat);
        check_result("5/0", 32'hFFFFFFFF, 32'd5, 1'b1, 1, lat);
    endtask

    task automatic test_back_to_back;
        int lat;
        // done is high from the previous operation here
        launch(32'd1000, 32'd10);
        total++;
        if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b accept: got done=%b dz=%b busy=%b expected 0/0/1", done, div_by_zero, busy);
        else passed++;
        wait_done(lat);
        check_result("1000/10", 32'd100, 32'd0, 1'b0, 33, lat);
    endtask

    task automatic test_start_while_busy;
        int lat;
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        wait_done(lat);
        check_result("busy start", 32'd14, 32'd2, 1'b0, 23, lat);
    endtask

    task automatic test_reset_mid_op;
        int lat;
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({quotient, remainder} !== '0 || {busy, done, div_by_zero} !== 3'b000)
            $display("FAIL mid-op reset: got q=%h r=%h flags=%b expected all 0", quotient, remainder, {busy, done, div_by_zero});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        launch(32'd9, 32'd3);
        wait_done(lat);
        check_result("9/3 after reset", 32'd3, 32'd0, 1'b0, 33, lat);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_basic;
`ifdef DIV_SIGNED_EN
        test_signed;
`else
        test_unsigned;
`endif
        test_div_zero;
        test_back_to_back;
        test_start_while_busy;
        test_reset_mid_op;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
